dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in storage; allowed values are powers of two, 4..4096.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response valid; allowed range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address (ALUResultM).
REQ-009 SHALL have port req_wdata, input, 32 bits: store data (WriteDataM).
REQ-010 SHALL have port req_funct3, input, 3 bits: access size and sign, using RV32I load/store funct3 encoding.
REQ-011 SHALL have port rsp_valid, output, 1 bit: the response is presented.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the initiator takes the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: access fault.
REQ-015 SHALL have port dm0, output, 32 bits: live contents of word 0, for debug.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE.
- Acceptance = req_valid & req_ready.
REQ-017 On acceptance:
- Latch we, addr, wdata and funct3.
- Load the latency counter with LATENCY-1.
- Go to WAIT.
- If LATENCY=1, go directly to RESP.
REQ-018 WAIT decrements the counter by 1 per cycle; at counter=0 it performs the access and goes to RESP, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-019 RESP holds rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_valid & rsp_ready, then goes to IDLE; back-to-back throughput is one request per LATENCY+1 cycles minimum.
REQ-020 Word index = addr[log2(DEPTH)+1:2].
- addr >= 4*DEPTH: rsp_err=1, no store, rdata=0.
REQ-021 Load data:
- LB/LH sign-extend the selected byte/half (byte lane addr[1:0], half lane addr[1]).
- LBU/LHU zero-extend.
- LW returns the full word.
REQ-022 Stores:
- SB/SH update only the addressed lane(s).
- SW updates all 4 bytes.
- The write occurs once, at the WAIT→RESP transition.
REQ-023 Unsupported funct3 (3, 6 or 7; and 4 or 5 with we=1) SHALL give rsp_err=1 with no state change.
REQ-024 req_valid SHALL be ignored outside IDLE; request inputs may change freely after acceptance.
REQ-025 A load to the word written by the immediately previous store SHALL return the new data.

Reset
REQ-026 rst low, at any time including mid-WAIT or RESP, SHALL:
- Force IDLE.
- Drive rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Clear all storage to zero (so dm0=0).
- Drop any pending store.
REQ-027 req_ready SHALL be 0 while rst is low and 1 on the first cycle after release.

Configuration
REQ-028 Macro DMEM_MISALIGN_CHECK_EN:
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]≠0 gives rsp_err=1, no store, rdata=0.
- Undefined: the address is aligned down to the access size and completes with rsp_err=0.

Structure
REQ-029 The shared package SHALL hold:
- the FSM state enum;
- funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2);
- the default DEPTH and LATENCY.
REQ-030 Sub-module dmem_lane_ext SHALL be purely combinational and produce the load extraction/extension and the store byte-enable merge.

Verification
REQ-031 After reset, SW addr 0x10 data 0xDEADBEEF, then LW 0x10: rsp_rdata=0xDEADBEEF, rsp_err=0, and each rsp_valid is exactly 2 cycles after acceptance.
REQ-032 Word 0x20 = 0x000080F0:
- LB 0x20 → 0xFFFFFFF0.
- LBU 0x21 → 0x00000080.
- LH 0x20 → 0xFFFF80F0.
- SB 0x23 data 0x11, then LW 0x20 → 0x110080F0.
REQ-033 With rsp_ready held 0 for 5 cycles in RESP: rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until after the handshake.
REQ-034 LW 0x402 with the macro defined → rsp_err=1, rdata=0; without the macro → returns the word at 0x400. LW at 4*DEPTH → rsp_err=1 in both builds.
REQ-035 SW 0x0 data 0x12345678 with rst pulsed low during WAIT: no write (dm0=0), rsp_valid=0, req_ready=1 one cycle after release.
REQ-036 LATENCY=1 build: SW then LW of 0x4 with rsp_ready tied 1 → response 1 cycle after each acceptance, 2-cycle throughput, read data matches.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, RV32I
// load/store funct3 encodings, default geometry and a funct3 legality helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store encodings
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;

  // Unsigned loads have no store counterpart; 3, 6 and 7 are never legal.
  function automatic logic funct3_bad(input logic we, input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b0;
      F3_LBU, F3_LHU:      return we;
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// store merge of the addressed lanes into the current word.
module dmem_lane_ext
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;

  // Select the addressed byte/half and extend it according to the load type.
  always_comb begin
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = word;
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Replicate store data across lanes and pick the lanes that get written.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (funct3)
      F3_SB: begin
        byte_en    = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_SH: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_SW:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_word[8*gi +: 8] = byte_en[gi] ? wdata_lane[8*gi +: 8] : word[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed access latency and valid/ready handshakes.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned halfword/word
// accesses into errors; without it they are aligned down to the access size.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm0
);

  localparam int AW = $clog2(DEPTH);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] mem [DEPTH];

  logic        accept, do_access;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic [AW-1:0] idx;
  logic        range_err, f3_err, align_err, acc_err;
  logic [31:0] load_data, store_word;

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign dm0       = mem[0];

  if (LATENCY == 1) begin : g_direct
    // Single-cycle latency performs the access on the acceptance edge itself.
    assign acc_we    = req_we;
    assign acc_addr  = req_addr;
    assign acc_wdata = req_wdata;
    assign acc_f3    = req_funct3;
    assign do_access = accept;
  end else begin : g_latched
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [2:0]  lat_f3;

    // Capture the request so the initiator may change its inputs afterwards.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lat_we    <= 1'b0;
        lat_addr  <= '0;
        lat_wdata <= '0;
        lat_f3    <= '0;
      end else if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
      end
    end

    assign acc_we    = lat_we;
    assign acc_addr  = lat_addr;
    assign acc_wdata = lat_wdata;
    assign acc_f3    = lat_f3;
    // The access is the last WAIT decrement, landing in RESP LATENCY cycles on.
    assign do_access = (state == WAIT) && (cnt == 4'd1);
  end

  assign idx       = acc_addr[AW+1:2];
  assign range_err = |acc_addr[31:AW+2];
  assign f3_err    = funct3_bad(acc_we, acc_f3);

`ifdef DMEM_MISALIGN_CHECK_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    align_err = 1'b0;
    case (acc_f3)
      F3_LH, F3_LHU: align_err = acc_addr[0];
      F3_LW:         align_err = |acc_addr[1:0];
      default:       align_err = 1'b0;
    endcase
  end
`else
  assign align_err = 1'b0;
`endif

  assign acc_err = range_err || f3_err || align_err;

  dmem_lane_ext u_lane_ext (
    .funct3     (acc_f3),
    .lane       (acc_addr[1:0]),
    .word       (mem[idx]),
    .wdata      (acc_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next-state and latency counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Response payload is captured at the access and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || acc_we) ? '0 : load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  // Storage: cleared by reset, written once per legal store at the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_access && acc_we && !acc_err) begin
      mem[idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts
// each response at issue time; a monitor checks payload, latency and hold
// stability at every handshake. A second LATENCY=1 instance is exercised too.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int DEPTH  = 512;
  localparam int LAT    = 2;
  localparam int DEPTH1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, dm0;

  logic        req_valid1 = 1'b0, req_we1 = 1'b0;
  logic        rsp_ready1;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic [2:0]  req_funct31 = '0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1, dm0_1;
  assign rsp_ready1 = 1'b1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dm0(dm0)
  );

  dmem_responder #(.DEPTH(DEPTH1), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_funct3(req_funct31), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .dm0(dm0_1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold     = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mbytes [4*DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array; sizes and extension from funct3.
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                output logic err, output logic [31:0] rdata);
    int size = 4;
    bit sgn = 1'b0;
    bit legal = 1'b1;
    int a, base;
    logic [31:0] v;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err   = !legal || (addr >= 32'(4*DEPTH));
    rdata = '0;
    if (err) return;
    a = int'(addr);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a % size != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = a - (a % size);
    if (we) begin
      for (int b = 0; b < size; b++) mbytes[base+b] = wdata[8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < size; b++) v = v | (32'(mbytes[base+b]) << (8*b));
      if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rdata = v;
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model(we, addr, wdata, f3, e.err, e.rdata);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Response initiator readiness, randomised unless a hold is requested.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each handshake against the oldest expectation.
  initial begin
    bit in_rsp = 1'b0;
    int first = 0;
    logic [31:0] hd = '0;
    logic he = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_rsp = 1'b0;
      end else if (rsp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!in_rsp) begin
          in_rsp = 1'b1; first = cyc; hd = rsp_rdata; he = rsp_err;
        end else begin
          chk("rdata_stable", rsp_rdata, hd);
          chk("err_stable", 32'(rsp_err), 32'(he));
        end
        if (rsp_ready) begin
          in_rsp = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rdata", rsp_rdata, e.rdata);
            chk("err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(first - e.acc), 32'(LAT));
            $display("rsp cyc=%0d rdata=0x%08h err=%0d latency=%0d", cyc, rsp_rdata, rsp_err, first - e.acc);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_dm0", dm0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);

    // LATENCY=1 instance: SW then LW of 0x4, rsp_ready tied high
    req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'hA5A55A5A; req_funct31 = 3'd2;
    chk("l1_accept_sw", 32'(req_ready1), 32'd1);
    @(posedge clk); #1;
    req_we1 = 1'b0; req_wdata1 = 32'h0;
    @(negedge clk);
    chk("l1_sw_rsp_valid", 32'(rsp_valid1), 32'd1);
    chk("l1_sw_rsp_err", 32'(rsp_err1), 32'd0);
    chk("l1_sw_rdata", rsp_rdata1, 32'd0);
    chk("l1_busy", 32'(req_ready1), 32'd0);
    @(negedge clk);
    chk("l1_accept_lw", 32'(req_ready1), 32'd1);
    chk("l1_idle_valid", 32'(rsp_valid1), 32'd0);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("l1_lw_rsp_valid", 32'(rsp_valid1), 32'd1);
    chk("l1_lw_rdata", rsp_rdata1, 32'hA5A55A5A);
    chk("l1_lw_err", 32'(rsp_err1), 32'd0);
    $display("l1 lw rdata=0x%08h err=%0d", rsp_rdata1, rsp_err1);
    @(negedge clk);
    chk("l1_dm0", dm0_1, 32'd0);

    // Store word then read back
    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    issue(1'b0, 32'h10, 32'h0, 3'd2);

    // Sub-word loads and a byte store
    issue(1'b1, 32'h20, 32'h000080F0, 3'd2);
    issue(1'b0, 32'h20, 32'h0, 3'd0);
    issue(1'b0, 32'h21, 32'h0, 3'd4);
    issue(1'b0, 32'h20, 32'h0, 3'd1);
    issue(1'b1, 32'h23, 32'h11, 3'd0);
    issue(1'b0, 32'h20, 32'h0, 3'd2);
    issue(1'b1, 32'h26, 32'hBEEF, 3'd1);
    issue(1'b0, 32'h26, 32'h0, 3'd5);
    drain();

    // Backpressure: response held, second request must wait
    hold = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 3'd2);
    fork
      begin
        repeat (8) @(negedge clk);
        hold = 1'b0;
      end
    join_none
    issue(1'b0, 32'h20, 32'h0, 3'd2);
    drain();

    // Range, alignment and illegal funct3
    issue(1'b1, 32'h400, 32'hCAFEF00D, 3'd2);
    issue(1'b0, 32'h402, 32'h0, 3'd2);
    issue(1'b0, 32'h403, 32'h0, 3'd5);
    issue(1'b0, 32'(4*DEPTH), 32'h0, 3'd2);
    issue(1'b1, 32'(4*DEPTH), 32'h5555AAAA, 3'd2);
    issue(1'b0, 32'(4*DEPTH-1), 32'h0, 3'd0);
    issue(1'b1, 32'h10, 32'h77777777, 3'd4);
    issue(1'b0, 32'h10, 32'h0, 3'd3);
    issue(1'b1, 32'h10, 32'h66666666, 3'd6);
    issue(1'b0, 32'h10, 32'h0, 3'd2);

    // Randomised traffic, concentrated on a small window to hit stored data
    for (int t = 0; t < 250; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 4*DEPTH + 64)) : 32'($urandom_range(0, 63));
      issue(1'($urandom), a, $urandom, 3'($urandom));
    end
    drain();
    chk("dm0_model", dm0, {mbytes[3], mbytes[2], mbytes[1], mbytes[0]});

    // Reset during WAIT drops the pending store
    issue(1'b1, 32'h0, 32'h12345678, 3'd2);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_dm0", dm0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_dm0", dm0, 32'd0);
    chk("post_rst_idle", 32'(rsp_valid), 32'd0);
    issue(1'b0, 32'h0, 32'h0, 3'd2);
    issue(1'b0, 32'h10, 32'h0, 3'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
